// File: rtl/mem_access_ctrl_if.sv
// Word-wide data memory port: the controller is the master, the memory is the slave.
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  m_req;
    logic                  m_we;
    logic [ADDR_WIDTH-3:0] m_addr;
    logic [DATA_WIDTH-1:0] m_wdata;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic                  m_ready;

    modport master (
        output m_req,
        output m_we,
        output m_addr,
        output m_wdata,
        input  m_rdata,
        input  m_ready
    );

    modport slave (
        input  m_req,
        input  m_we,
        input  m_addr,
        input  m_wdata,
        output m_rdata,
        output m_ready
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: issues word loads/stores, sign-extended byte loads and
// read-modify-write byte stores to a variable-latency memory, stalling the
// pipeline until the access completes.
module mem_access_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cache_en,
    input  logic                  mem_write,
    input  logic                  is_LB_SB,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [31:0]           stall_cycles,
    mem_access_ctrl_if.master     mem
);

    localparam int unsigned CNT_WIDTH  = 32;
    localparam int unsigned BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RMW_RD,
        RMW_WR,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  byte_q, byte_d;
    logic [DATA_WIDTH-1:0] merge_q, merge_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  m_req_q, m_req_d;
    logic                  m_we_q, m_we_d;
    logic [CNT_WIDTH-1:0]  stall_cycles_q, stall_cycles_d;

    logic                  stall_c;
    logic [1:0]            lane_sel;
    logic [BYTE_WIDTH-1:0] rd_byte;
    logic [DATA_WIDTH-1:0] merged;

    assign lane_sel = addr_q[1:0];

    // Byte lane extraction for loads and lane merge for byte stores.
    always_comb begin
        rd_byte = mem.m_rdata[{lane_sel, 3'b000} +: BYTE_WIDTH];
        merged  = mem.m_rdata;
        merged[{lane_sel, 3'b000} +: BYTE_WIDTH] = wdata_q[BYTE_WIDTH-1:0];
    end

    // Next-state, buffer updates and registered memory-port controls.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        byte_d         = byte_q;
        merge_d        = merge_q;
        rdata_d        = rdata_q;
        m_req_d        = 1'b0;
        m_we_d         = 1'b0;
        stall_c        = 1'b0;
        stall_cycles_d = stall_cycles_q;

        case (state_q)
            IDLE: begin
                if (cache_en) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    byte_d  = is_LB_SB;
                    if (!mem_write) begin
                        state_d = RD_WAIT;
                    end else if (!is_LB_SB) begin
                        state_d = WR_WAIT;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            RD_WAIT: begin
                if (mem.m_ready) begin
                    if (byte_q) begin
                        rdata_d = {{(DATA_WIDTH-BYTE_WIDTH){rd_byte[BYTE_WIDTH-1]}}, rd_byte};
                    end else begin
                        rdata_d = mem.m_rdata;
                    end
                    state_d = DONE;
                end
            end
            WR_WAIT: begin
                if (mem.m_ready) begin
                    state_d = DONE;
                end
            end
            RMW_RD: begin
                if (mem.m_ready) begin
                    merge_d = merged;
                    state_d = RMW_WR;
                end
            end
            RMW_WR: begin
                if (mem.m_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // cache_en still reflects the retiring instruction here
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        m_req_d = (state_d inside {RD_WAIT, WR_WAIT, RMW_RD, RMW_WR});
        m_we_d  = (state_d inside {WR_WAIT, RMW_WR});

        stall_c = !reset &&
                  (((state_q != IDLE) && (state_q != DONE)) ||
                   ((state_q == IDLE) && cache_en));

        if (stall_c) begin
            stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
        end
    end

    // State and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            byte_q         <= 1'b0;
            merge_q        <= '0;
            rdata_q        <= '0;
            m_req_q        <= 1'b0;
            m_we_q         <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            byte_q         <= byte_d;
            merge_q        <= merge_d;
            rdata_q        <= rdata_d;
            m_req_q        <= m_req_d;
            m_we_q         <= m_we_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem.m_req   = m_req_q;
    assign mem.m_we    = m_we_q;
    assign mem.m_addr  = addr_q[ADDR_WIDTH-1:2];
    assign mem.m_wdata = (state_q == RMW_WR) ? merge_q : wdata_q;

    assign stall        = stall_c;
    assign rdata        = rdata_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed accesses push expected memory
// transactions and completions; a monitor pops and compares them.
module tb_mem_access_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cache_en;
    logic          mem_write;
    logic          is_lb_sb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          stall;
    logic [DW-1:0] rdata;
    logic [31:0]   stall_cycles;

    mem_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cache_en     (cache_en),
        .mem_write    (mem_write),
        .is_LB_SB     (is_lb_sb),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .rdata        (rdata),
        .stall_cycles (stall_cycles),
        .mem          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] maddr;
        logic [31:0] wd;
        logic        cont;
    } mem_ev_t;

    typedef struct {
        logic [31:0] rd;
        int          stalls;
        logic [31:0] total;
    } done_ev_t;

    mem_ev_t  mem_q[$];
    done_ev_t done_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Memory model: answers after lat cycles of m_req with mem_word on reads.
    logic        mdl_ready = 1'b0;
    logic        inj_ready = 1'b0;
    logic [31:0] mdl_rdata = 32'h0;
    logic [31:0] mem_word  = 32'h0;
    int          lat       = 1;
    int          cnt       = 0;

    assign bus.m_ready = mdl_ready | inj_ready;
    assign bus.m_rdata = mdl_rdata;

    always begin
        @(negedge clk);
        if (mdl_ready) begin
            mdl_ready = 1'b0;
            cnt       = 0;
        end
        if (reset || !bus.m_req) begin
            cnt = 0;
        end else begin
            cnt++;
            if (cnt == lat) begin
                mdl_ready = 1'b1;
                if (!bus.m_we) mdl_rdata = mem_word;
            end
        end
    end

    // Monitor: compares completions and memory transactions against the queues.
    logic        prev_stall = 1'b0;
    logic        prev_req   = 1'b0;
    logic        prev_ready = 1'b0;
    int          stall_run  = 0;
    logic        ref_we     = 1'b0;
    logic [31:0] ref_addr   = 32'h0;
    logic [31:0] ref_wd     = 32'h0;
    logic        start_cont = 1'b0;
    mem_ev_t     me;
    done_ev_t    de;

    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            prev_stall = 1'b0;
            prev_req   = 1'b0;
            prev_ready = 1'b0;
            stall_run  = 0;
        end else begin
            if (stall) begin
                stall_run++;
            end else if (prev_stall) begin
                if (done_q.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    de = done_q.pop_front();
                    check("done_rdata", rdata, de.rd);
                    check("done_stall_len", 32'(stall_run), 32'(de.stalls));
                    check("done_stall_cycles", stall_cycles, de.total);
                end
                stall_run = 0;
            end

            if (bus.m_req) begin
                if (!prev_req || prev_ready) begin
                    ref_we     = bus.m_we;
                    ref_addr   = 32'(bus.m_addr);
                    ref_wd     = bus.m_wdata;
                    start_cont = prev_req;
                end else begin
                    check("hold_we", 32'(bus.m_we), 32'(ref_we));
                    check("hold_addr", 32'(bus.m_addr), ref_addr);
                    check("hold_wdata", bus.m_wdata, ref_wd);
                end
            end else if (prev_req && !prev_ready) begin
                flag("req_dropped_before_ready");
            end

            if (bus.m_req && bus.m_ready) begin
                if (mem_q.size() == 0) begin
                    flag("unexpected_mem_access");
                end else begin
                    me = mem_q.pop_front();
                    check("mem_we", 32'(bus.m_we), 32'(me.we));
                    check("mem_addr", 32'(bus.m_addr), me.maddr);
                    if (me.we) check("mem_wdata", bus.m_wdata, me.wd);
                    check("mem_req_continuous", 32'(start_cont), 32'(me.cont));
                end
            end

            prev_stall = stall;
            prev_req   = bus.m_req;
            prev_ready = bus.m_ready;
        end
    end

    task automatic issue(input logic w, input logic b, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mw, input int l);
        cache_en  = 1'b1;
        mem_write = w;
        is_lb_sb  = b;
        addr      = a;
        wdata     = wd;
        mem_word  = mw;
        lat       = l;
    endtask

    task automatic push_mem(input logic we, input logic [31:0] ma, input logic [31:0] wd, input logic c);
        mem_ev_t e;
        e.we = we; e.maddr = ma; e.wd = wd; e.cont = c;
        mem_q.push_back(e);
    endtask

    task automatic push_done(input logic [31:0] rd, input int s, input logic [31:0] t);
        done_ev_t e;
        e.rd = rd; e.stalls = s; e.total = t;
        done_q.push_back(e);
    endtask

    // Returns in the DONE cycle, after the monitor has sampled it.
    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #2;
            if (!stall) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) flag({name, "_timeout"});
    endtask

    task automatic idle_after;
        cache_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        reset     = 1'b1;
        cache_en  = 1'b0;
        mem_write = 1'b0;
        is_lb_sb  = 1'b0;
        addr      = '0;
        wdata     = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_m_req", 32'(bus.m_req), 32'h0);
        check("rst_m_we", 32'(bus.m_we), 32'h0);
        check("rst_m_addr", 32'(bus.m_addr), 32'h0);
        check("rst_m_wdata", bus.m_wdata, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_stall_cycles", stall_cycles, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // LW 0x100
        push_mem(1'b0, 32'h40, 32'h0, 1'b0);
        push_done(32'hDEADBEEF, 2, 32'd2);
        issue(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        wait_done("lw_100");
        idle_after();

        // LB 0x103 -> lane 3 = 0x80, sign-extended
        push_mem(1'b0, 32'h40, 32'h0, 1'b0);
        push_done(32'hFFFFFF80, 2, 32'd4);
        issue(1'b0, 1'b1, 32'h103, 32'h0, 32'h80112233, 1);
        wait_done("lb_103");
        idle_after();

        // LB 0x101 -> lane 1 = 0x22
        push_mem(1'b0, 32'h40, 32'h0, 1'b0);
        push_done(32'h00000022, 2, 32'd6);
        issue(1'b0, 1'b1, 32'h101, 32'h0, 32'h80112233, 1);
        wait_done("lb_101");
        idle_after();

        // SB 0x102: read 0x11223344, write 0x11AB3344 with m_req continuous
        push_mem(1'b0, 32'h40, 32'h0, 1'b0);
        push_mem(1'b1, 32'h40, 32'h11AB3344, 1'b1);
        push_done(32'h00000022, 3, 32'd9);
        issue(1'b1, 1'b1, 32'h102, 32'h000000AB, 32'h11223344, 1);
        wait_done("sb_102");
        idle_after();

        // SW 0x204 with ready in the 5th request cycle
        push_mem(1'b1, 32'h81, 32'hCAFEF00D, 1'b0);
        push_done(32'h00000022, 6, 32'd15);
        issue(1'b1, 1'b0, 32'h204, 32'hCAFEF00D, 32'h0, 5);
        wait_done("sw_204");
        idle_after();

        // Back-to-back LW then SW, next request presented during DONE
        push_mem(1'b0, 32'h80, 32'h0, 1'b0);
        push_done(32'h12345678, 3, 32'd18);
        push_mem(1'b1, 32'h82, 32'h0BADF00D, 1'b0);
        push_done(32'h12345678, 2, 32'd20);
        issue(1'b0, 1'b0, 32'h200, 32'h0, 32'h12345678, 2);
        wait_done("b2b_lw");
        issue(1'b1, 1'b0, 32'h208, 32'h0BADF00D, 32'h0, 1);
        wait_done("b2b_sw");
        idle_after();
        repeat (2) @(negedge clk);

        // Reset during RMW_RD: the access is abandoned
        issue(1'b1, 1'b1, 32'h102, 32'h00000055, 32'h0, 100);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #2;
            if (bus.m_req && !bus.m_we) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) flag("rmw_rd_timeout");
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("midrst_m_req", 32'(bus.m_req), 32'h0);
        check("midrst_stall", 32'(stall), 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_stall_cycles", stall_cycles, 32'h0);
        cache_en = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        inj_ready = 1'b1;
        @(negedge clk);
        inj_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("late_ready_m_req", 32'(bus.m_req), 32'h0);
        check("late_ready_stall", 32'(stall), 32'h0);
        check("late_ready_rdata", rdata, 32'h0);
        check("late_ready_stall_cycles", stall_cycles, 32'h0);

        check("mem_q_drained", 32'(mem_q.size()), 32'h0);
        check("done_q_drained", 32'(done_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle sequencer between the MEM pipeline stage and a word-wide data memory with a variable-latency ready handshake.
- Takes the decoded memory request (cache_en, mem_write, is_LB_SB) plus address and store data, and drives the memory port.
- Stalls the pipeline while an access is outstanding.
- Implements byte loads (sign-extended) and byte stores (read-modify-write on the containing word); little-endian byte lanes.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32, byte-lane logic relies on it.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- cache_en  in  1  memory request present in MEM stage; held stable while stall=1.
- mem_write  in  1  1=store, 0=load.
- is_LB_SB  in  1  1=byte access, 0=word access.
- addr  in  ADDR_WIDTH  byte address from ALU.
- wdata  in  32  store data; byte stores use wdata[7:0].
- stall  out  1  freeze PC and pipeline registers up to MEM.
- rdata  out  32  load result; valid in DONE.
- m_req  out  1  memory request, held until m_ready.
- m_we  out  1  memory write enable, qualifies m_req.
- m_addr  out  ADDR_WIDTH-2  word address, addr[ADDR_WIDTH-1:2].
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid with m_ready on a read.
- m_ready  in  1  memory completes the current access this cycle; ignored when m_req=0.
- stall_cycles  out  32  count of cycles with stall=1.

Behaviour:
- States: IDLE, RD_WAIT, WR_WAIT, RMW_RD, RMW_WR, DONE. The FSM is Moore for all m_* outputs; they are driven from registered state and latched buffers only.
- IDLE, cache_en=1: latch addr, wdata, mem_write and is_LB_SB. Next state:
  - RD_WAIT if load.
  - WR_WAIT if word store.
  - RMW_RD if byte store.
- IDLE, cache_en=0: stay in IDLE.
- RD_WAIT: m_req=1, m_we=0. On m_ready, capture the result into rdata and go to DONE.
  - Word load: rdata = m_rdata.
  - Byte load: rdata = sign-extend of lane addr[1:0]; lane n is bits [8n+7:8n].
- WR_WAIT: m_req=1, m_we=1, m_wdata=latched wdata. On m_ready, go to DONE.
- RMW_RD: m_req=1, m_we=0. On m_ready, merge latched wdata[7:0] into m_rdata at lane addr[1:0], store the result in the merge buffer, and go to RMW_WR.
- RMW_WR: m_req=1, m_we=1, m_wdata=merge buffer. On m_ready, go to DONE.
- DONE: stall=0 and rdata is valid. The pipeline advances at this edge. Next state is IDLE unconditionally; cache_en is ignored in DONE because it still reflects the completed instruction.
- stall equation: stall = (state∉{IDLE,DONE}) | (state==IDLE & cache_en). stall is forced to 0 while reset=1.
- Word accesses ignore addr[1:0]; no misalignment trap.
- m_req stays high, with m_addr, m_we and m_wdata stable, until the m_ready cycle. m_req drops in the following cycle unless the FSM moves RMW_RD→RMW_WR, in which case it stays high and m_we rises.
- Latency: with m_ready in the first m_req cycle, a load or word store takes 3 cycles (IDLE, WAIT, DONE) with 2 stall cycles. A byte store takes 4 cycles with 3 stall cycles.
- rdata holds its last value outside DONE. For stores, rdata is unchanged.
- stall_cycles increments on each cycle with stall=1 and wraps from 0xFFFFFFFF to 0.
- Reset values: state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, rdata=0, stall_cycles=0, latch and merge buffers=0.
- Reset mid-access: the FSM returns to IDLE next edge, m_req=0, and the outstanding access is abandoned; the memory must tolerate a dropped request. A late m_ready while m_req=0 is ignored.

Test Plan:
- LW 0x100, m_ready one cycle after m_req, m_rdata=0xDEADBEEF:
  - m_addr=0x40, m_we=0.
  - stall=1 for 2 cycles.
  - DONE shows rdata=0xDEADBEEF.
  - stall_cycles=2.
- LB addr 0x103, m_rdata=0x80112233 → rdata=0xFFFFFF80. LB addr 0x101 with the same word → rdata=0x00000022.
- SB addr 0x102, wdata=0x000000AB, memory word 0x11223344:
  - Read, then write with m_wdata=0x11AB3344.
  - m_req stays continuous across the RMW_RD→RMW_WR boundary.
  - 3 stall cycles.
- SW addr 0x204, wdata=0xCAFEF00D, m_ready delayed 5 cycles:
  - m_req, m_we, m_addr=0x81 and m_wdata remain stable for all 5 cycles.
  - stall=1 for 6 cycles.
- Back-to-back LW then SW, each cache_en held through stall: the second access starts from IDLE in the cycle after DONE and is never issued twice.
- reset asserted during RMW_RD:
  - Next cycle m_req=0, stall=0, rdata=0, stall_cycles=0.
  - A subsequent m_ready pulse causes no state change.
